// File: rtl/console_defs.sv
// Console layout shared by the write side and the scan-out block: geometry,
// control codes and the text/font region bases inside the 16-bit memory map.
package console_defs;
  localparam int COLS = 80;
  localparam int ROWS = 48;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // Bit 13 selects the region: clear for text RAM, set for the font ROM.
  localparam logic [15:0] TEXT_BASE = 16'h0000;
  localparam logic [15:0] FONT_BASE = 16'h2000;

  function automatic logic isPrintable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction
endpackage

// File: rtl/console_addr.sv
// Cell address of (col,row) in text RAM: col + 80*row. Shift-add only, so the
// scan-out side can reuse it without a multiplier.
module console_addr (
  input  logic [6:0]  col,
  input  logic [5:0]  row,
  output logic [12:0] addr
);
  logic [12:0] rowW;

  assign rowW = {7'd0, row};
  assign addr = (rowW << 6) + (rowW << 4) + {6'd0, col};
endmodule

// File: rtl/console_writer.sv
// Byte-stream writer for the 80x48 text console: places printable codes at the
// cursor, handles CR/LF/BS/FF and blanks rows as the cursor enters them.
module console_writer
  import console_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic [15:0] memAddr,
  output logic [7:0]  memData,
  output logic        memWrite,
  output logic [6:0]  cursorCol,
  output logic [5:0]  cursorRow,
  output logic        busy
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CLR_ROW = 2'd1;
  localparam logic [1:0] CLR_ALL = 2'd2;

  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
  localparam logic [11:0] LAST_ROW_IDX = 12'(COLS - 1);
  localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

  logic [1:0]  state;
  logic [11:0] clrIdx;
  logic [6:0]  colM1;
  logic [5:0]  nextRow;
  logic [12:0] curAddr, bsAddr, rowClrAddr;
  logic        accept;

  assign inReady = (state == IDLE);
  assign busy    = (state != IDLE);
  assign accept  = inValid && inReady;
  assign colM1   = cursorCol - 7'd1;
  assign nextRow = (cursorRow == LAST_ROW) ? 6'd0 : cursorRow + 6'd1;

  console_addr uCurAddr (.col(cursorCol), .row(cursorRow), .addr(curAddr));
  console_addr uBsAddr  (.col(colM1), .row(cursorRow), .addr(bsAddr));
  console_addr uClrAddr (.col(clrIdx[6:0]), .row(cursorRow), .addr(rowClrAddr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLR_ALL;
      clrIdx    <= 12'd0;
      cursorCol <= 7'd0;
      cursorRow <= 6'd0;
      memWrite  <= 1'b0;
      memAddr   <= 16'd0;
      memData   <= 8'd0;
    end else begin
      memWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (isPrintable(inData)) begin
              memWrite <= 1'b1;
              memAddr  <= TEXT_BASE | {3'd0, curAddr};
              memData  <= inData;
              if (cursorCol == LAST_COL) begin
                // Wrap: the char lands on this row, the next row is blanked.
                cursorCol <= 7'd0;
                cursorRow <= nextRow;
                clrIdx    <= 12'd0;
                state     <= CLR_ROW;
              end else begin
                cursorCol <= cursorCol + 7'd1;
              end
            end else begin
              case (inData)
                CH_CR: cursorCol <= 7'd0;
                CH_BS: begin
                  if (cursorCol != 7'd0) begin
                    memWrite  <= 1'b1;
                    memAddr   <= TEXT_BASE | {3'd0, bsAddr};
                    memData   <= BLANK;
                    cursorCol <= colM1;
                  end
                end
                CH_LF: begin
                  cursorRow <= nextRow;
                  clrIdx    <= 12'd0;
                  state     <= CLR_ROW;
                end
                CH_FF: begin
                  cursorCol <= 7'd0;
                  cursorRow <= 6'd0;
                  clrIdx    <= 12'd0;
                  state     <= CLR_ALL;
                end
                default: ;
              endcase
            end
          end
        end
        CLR_ROW: begin
          memWrite <= 1'b1;
          memAddr  <= TEXT_BASE | {3'd0, rowClrAddr};
          memData  <= BLANK;
          if (clrIdx == LAST_ROW_IDX) state <= IDLE;
          else clrIdx <= clrIdx + 12'd1;
        end
        CLR_ALL: begin
          memWrite <= 1'b1;
          memAddr  <= TEXT_BASE | {4'd0, clrIdx};
          memData  <= BLANK;
          if (clrIdx == LAST_CELL) state <= IDLE;
          else clrIdx <= clrIdx + 12'd1;
        end
        default: begin
          clrIdx <= 12'd0;
          state  <= CLR_ALL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer: screen clear, printing, wrap, scroll-wrap,
// control codes and reset during a full clear.
module tb_console_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic [15:0] memAddr;
  logic [7:0]  memData;
  logic        memWrite;
  logic [6:0]  cursorCol;
  logic [5:0]  cursorRow;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [23:0] wq[$];
  int          wc[$];

  console_writer dut (
    .clk(clk), .rst_n(rst_n), .inData(inData), .inValid(inValid),
    .inReady(inReady), .memAddr(memAddr), .memData(memData),
    .memWrite(memWrite), .cursorCol(cursorCol), .cursorRow(cursorRow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && memWrite) begin
      wq.push_back({memAddr, memData});
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearQ();
    wq.delete();
    wc.delete();
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    inData  = b;
    inValid = 1'b1;
    while (!inReady && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) chk("sendTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  task automatic waitIdle(output int cnt);
    cnt = 0;
    forever begin
      @(negedge clk);
      if (inReady || cnt >= 5000) break;
      cnt++;
    end
    if (!inReady) chk("idleTimeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int c;
    waitIdle(c);
    @(negedge clk);
  endtask

  task automatic checkFullClear(input string tag);
    int bad;
    bad = 0;
    chk({tag, "Count"}, wq.size(), 3840);
    if (wq.size() == 3840)
      for (int i = 0; i < 3840; i++)
        if (wq[i] !== {16'(i), 8'h20}) bad++;
    chk({tag, "Seq"}, bad, 0);
  endtask

  initial begin
    int cnt, n;
    rst_n = 1'b0;
    inData = 8'h00;
    inValid = 1'b0;

    // Reset, then full screen clear
    repeat (2) @(posedge clk);
    #1;
    chk("rstBusy", busy, 1);
    chk("rstReady", inReady, 0);
    chk("rstWrite", memWrite, 0);
    chk("rstAddr", memAddr, 0);
    chk("rstCursor", {cursorCol, cursorRow}, 0);
    clearQ();
    rst_n = 1'b1;
    waitIdle(cnt);
    @(negedge clk);
    chk("clrAllLow", cnt, 3840);
    checkFullClear("clrAll");
    chk("clrAllCursor", {cursorCol, cursorRow}, 0);

    // Back-to-back printable
    clearQ();
    sendByte(8'h41);
    sendByte(8'h42);
    drain();
    chk("abCount", wq.size(), 2);
    chk("abW0", wq[0], {16'd0, 8'h41});
    chk("abW1", wq[1], {16'd1, 8'h42});
    chk("abSpacing", wc[1] - wc[0], 1);
    chk("abCol", cursorCol, 2);

    // Move to (0,5), then fill the row to force a wrap
    sendByte(8'h0D);
    for (int i = 0; i < 5; i++) begin
      sendByte(8'h0A);
      drain();
    end
    chk("row5", {cursorCol, cursorRow}, {7'd0, 6'd5});
    clearQ();
    for (int i = 0; i < 80; i++) sendByte(8'h58);
    waitIdle(cnt);
    @(negedge clk);
    chk("wrapLow", cnt, 80);
    chk("wrapCount", wq.size(), 160);
    chk("wrapFirst", wq[0], {16'd400, 8'h58});
    chk("wrapLastChar", wq[79], {16'd479, 8'h58});
    chk("wrapClrFirst", wq[80], {16'd480, 8'h20});
    chk("wrapClrLast", wq[159], {16'd559, 8'h20});
    chk("wrapCursor", {cursorCol, cursorRow}, {7'd0, 6'd6});

    // LF on the last row wraps to row 0 and keeps the column
    sendByte(8'h51);
    drain();
    for (int i = 0; i < 41; i++) begin
      sendByte(8'h0A);
      drain();
    end
    chk("row47", {cursorCol, cursorRow}, {7'd1, 6'd47});
    clearQ();
    sendByte(8'h0A);
    drain();
    chk("lfWrapCursor", {cursorCol, cursorRow}, {7'd1, 6'd0});
    chk("lfWrapCount", wq.size(), 80);
    chk("lfWrapFirst", wq[0], {16'd0, 8'h20});
    chk("lfWrapLast", wq[79], {16'd79, 8'h20});

    // BS, CR, BS at col 0, unknown code
    sendByte(8'h61);
    sendByte(8'h62);
    drain();
    chk("preBsCol", cursorCol, 3);
    clearQ();
    sendByte(8'h08);
    drain();
    chk("bsCount", wq.size(), 1);
    chk("bsWrite", wq[0], {16'd2, 8'h20});
    chk("bsCol", cursorCol, 2);
    sendByte(8'h0D);
    drain();
    chk("crCol", cursorCol, 0);
    sendByte(8'h08);
    drain();
    chk("bs0Col", {cursorCol, cursorRow}, {7'd0, 6'd0});
    sendByte(8'h07);
    drain();
    chk("dropCursor", {cursorCol, cursorRow}, {7'd0, 6'd0});
    chk("ctlWrites", wq.size(), 1);

    // FF mid-screen, then reset in the middle of the clear
    sendByte(8'h5A);
    drain();
    sendByte(8'h0C);
    #1;
    chk("ffCursor", {cursorCol, cursorRow}, 0);
    chk("ffBusy", busy, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(memWrite && memAddr == 16'd1000) && n < 5000);
    chk("ffReach1000", memAddr, 1000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midRstWrite", memWrite, 0);
    chk("midRstBusy", busy, 1);
    clearQ();
    rst_n = 1'b1;
    waitIdle(cnt);
    @(negedge clk);
    chk("restartLow", cnt, 3840);
    checkFullClear("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
